clock_report_tx: RTL and testbench

//   Transmit side of the UART command interface. On request, formats the six BCD clock digits as ASCII
//   "HH:MM:SS\n" (or the fixed string "ERROR!\n") and serialises the bytes on the tx line as 8N1.

---
 rtl/clock_report_tx.sv | 179 +++++++++++++++++
 tb/tb_clock_report_tx.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/clock_report_tx.sv
// UART transmitter for clock reports: formats "HH:MM:SS\n" or "ERROR!\n" and sends it as 8N1.
// Build option CLOCK_REPORT_CR_EN inserts a carriage return (8'h0D) before the final line feed.
module clock_report_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       report_req,
  input  logic       err_req,
  input  logic [3:0] clock1,
  input  logic [3:0] clock2,
  input  logic [3:0] clock3,
  input  logic [3:0] clock4,
  input  logic [3:0] clock5,
  input  logic [3:0] clock6,
  output logic       tx,
  output logic       busy,
  output logic       done
);

`ifdef CLOCK_REPORT_CR_EN
  localparam int TIME_LEN = 10;
  localparam int ERR_LEN  = 8;
`else
  localparam int TIME_LEN = 9;
  localparam int ERR_LEN  = 7;
`endif
  localparam int MAX_LEN = 10;
  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state_q;
  logic [15:0]            bit_cnt_q;
  logic [2:0]             bit_idx_q;
  logic [3:0]             byte_idx_q;
  logic [3:0]             last_idx_q;
  logic [MAX_LEN*8-1:0]   msg_q;
  logic                   tx_q;
  logic                   busy_q;
  logic                   done_q;

  logic [7:0]             cur_byte;
  logic                   bit_last;
  logic                   req;

  function automatic logic [7:0] digit_ascii(input logic [3:0] d);
    return (d <= 4'd9) ? {4'h3, d} : 8'h3F;
  endfunction

  // Byte 0 of a message sits in bits [7:0].
  function automatic logic [MAX_LEN*8-1:0] time_msg(
    input logic [3:0] h1, input logic [3:0] h0,
    input logic [3:0] m1, input logic [3:0] m0,
    input logic [3:0] s1, input logic [3:0] s0
  );
    logic [MAX_LEN*8-1:0] m;
    m        = '0;
    m[7:0]   = digit_ascii(h1);
    m[15:8]  = digit_ascii(h0);
    m[23:16] = 8'h3A;
    m[31:24] = digit_ascii(m1);
    m[39:32] = digit_ascii(m0);
    m[47:40] = 8'h3A;
    m[55:48] = digit_ascii(s1);
    m[63:56] = digit_ascii(s0);
`ifdef CLOCK_REPORT_CR_EN
    m[71:64] = 8'h0D;
    m[79:72] = 8'h0A;
`else
    m[71:64] = 8'h0A;
`endif
    return m;
  endfunction

  function automatic logic [MAX_LEN*8-1:0] error_msg();
    logic [MAX_LEN*8-1:0] m;
    m        = '0;
    m[7:0]   = 8'h45;
    m[15:8]  = 8'h52;
    m[23:16] = 8'h52;
    m[31:24] = 8'h4F;
    m[39:32] = 8'h52;
    m[47:40] = 8'h21;
`ifdef CLOCK_REPORT_CR_EN
    m[55:48] = 8'h0D;
    m[63:56] = 8'h0A;
`else
    m[55:48] = 8'h0A;
`endif
    return m;
  endfunction

  assign cur_byte = msg_q[{byte_idx_q, 3'b000} +: 8];
  assign bit_last = (bit_cnt_q == BIT_LAST);
  assign req      = report_req | err_req;

  // Message buffer is pure data: captured at acceptance, never reset.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && req) begin
      msg_q <= err_req ? error_msg()
                       : time_msg(clock1, clock2, clock3, clock4, clock5, clock6);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      last_idx_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            state_q    <= START;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            last_idx_q <= err_req ? 4'(ERR_LEN - 1) : 4'(TIME_LEN - 1);
          end
        end
        START: begin
          if (bit_last) begin
            bit_cnt_q <= '0;
            state_q   <= DATA;
            tx_q      <= cur_byte[0];
          end else begin
            bit_cnt_q <= bit_cnt_q + 16'd1;
          end
        end
        DATA: begin
          if (bit_last) begin
            bit_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= cur_byte[bit_idx_q + 3'd1];
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + 16'd1;
          end
        end
        STOP: begin
          if (bit_last) begin
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            if (byte_idx_q == last_idx_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              byte_idx_q <= byte_idx_q + 4'd1;
              state_q    <= START;
              tx_q       <= 1'b0;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_clock_report_tx.sv
// Bench for clock_report_tx: decodes the tx waveform and compares against a text-level message model.
module tb_clock_report_tx;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst, report_req, err_req;
  logic [3:0] clock1, clock2, clock3, clock4, clock5, clock6;
  logic       tx, busy, done;

  int checks = 0;
  int errors = 0;

  typedef bit [7:0] bq_t[$];

  typedef struct {
    string       name;
    bit          e;
    bit          r;
    logic [23:0] dg;
    string       txt;
  } vec_t;

  clock_report_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .report_req(report_req), .err_req(err_req),
    .clock1(clock1), .clock2(clock2), .clock3(clock3),
    .clock4(clock4), .clock5(clock5), .clock6(clock6),
    .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic string digit_txt(input logic [3:0] d);
    if (d <= 9) return $sformatf("%0d", d);
    return "?";
  endfunction

  function automatic string time_txt(input logic [23:0] dg);
    return {digit_txt(dg[23:20]), digit_txt(dg[19:16]), ":",
            digit_txt(dg[15:12]), digit_txt(dg[11:8]), ":",
            digit_txt(dg[7:4]), digit_txt(dg[3:0])};
  endfunction

  function automatic bq_t msg_bytes(input string txt);
    bq_t q;
    for (int i = 0; i < txt.len(); i++) q.push_back(txt[i]);
`ifdef CLOCK_REPORT_CR_EN
    q.push_back(8'h0D);
`endif
    q.push_back(8'h0A);
    return q;
  endfunction

  task automatic set_digits(input logic [23:0] dg);
    {clock1, clock2, clock3, clock4, clock5, clock6} = dg;
  endtask

  // mode 0: plain; 1: second request + digit change mid-message; 2: request in the done cycle
  task automatic run_msg(input string name, input bit e, input bit r,
                         input logic [23:0] dg, input string txt, input int mode);
    bq_t exp;
    bit  s[$];
    int  n, dones, late_busy, late_done, late_low;
    exp = msg_bytes(txt);
    set_digits(dg);
    @(negedge clk);
    err_req = e; report_req = r;
    @(negedge clk);
    err_req = 1'b0; report_req = 1'b0;
    n = 0; dones = 0;
    while (busy === 1'b1 && n < 4000) begin
      s.push_back(tx);
      if (done === 1'b1) dones++;
      if (mode == 1 && n == 100) begin
        report_req = 1'b1;
        set_digits(~dg);
      end
      if (mode == 2 && n == exp.size() * 10 * CPB - 1) report_req = 1'b1;
      @(negedge clk);
      report_req = 1'b0;
      n++;
    end
    check({name, " busy_cycles"}, n, exp.size() * 10 * CPB);
    check({name, " done_while_busy"}, dones, 0);
    check({name, " done_pulse"}, done, 1);
    for (int j = 0; j < exp.size(); j++) begin
      logic [7:0] b;
      int base;
      base = j * 10 * CPB + CPB / 2;
      if (base + 9 * CPB < s.size()) begin
        for (int k = 0; k < 8; k++) b[k] = s[base + (k + 1) * CPB];
        check($sformatf("%s byte%0d", name, j), b, exp[j]);
        check($sformatf("%s frame%0d", name, j), {s[base], s[base + 9 * CPB]}, 2'b01);
      end else begin
        check($sformatf("%s byte%0d_missing", name, j), s.size(), base + 9 * CPB + 1);
      end
    end
    late_busy = 0; late_done = 0; late_low = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) late_busy++;
      if (done !== 1'b0) late_done++;
      if (tx !== 1'b1) late_low++;
    end
    check({name, " no_repeat_busy"}, late_busy, 0);
    check({name, " single_done"}, late_done, 0);
    check({name, " idle_tx"}, late_low, 0);
  endtask

  initial begin
    vec_t tbl[7];
    tbl[0] = '{"t1234", 1'b0, 1'b1, 24'h123456, "12:34:56"};
    tbl[1] = '{"both", 1'b1, 1'b1, 24'h999999, "ERROR!"};
    tbl[2] = '{"err", 1'b1, 1'b0, 24'h123456, "ERROR!"};
    tbl[3] = '{"zeros", 1'b0, 1'b1, 24'h000000, "00:00:00"};
    tbl[4] = '{"max", 1'b0, 1'b1, 24'h235959, "23:59:59"};
    tbl[5] = '{"badC", 1'b0, 1'b1, 24'h12C45F, "12:?4:5?"};
    tbl[6] = '{"badAB", 1'b0, 1'b1, 24'hABDE90, "??:??:90"};

    rst = 1'b1; report_req = 1'b0; err_req = 1'b0;
    set_digits(24'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("reset_tx%0d", i), tx, 1);
      check($sformatf("reset_busy%0d", i), busy, 0);
      check($sformatf("reset_done%0d", i), done, 0);
    end

    for (int i = 0; i < 7; i++)
      run_msg(tbl[i].name, tbl[i].e, tbl[i].r, tbl[i].dg, tbl[i].txt, 0);

    for (int i = 0; i < 6; i++) begin
      logic [23:0] dg;
      int kind;
      dg   = 24'($urandom);
      kind = $urandom_range(0, 2);
      run_msg($sformatf("rand%0d", i), kind != 0, kind != 1, dg,
              (kind == 0) ? time_txt(dg) : "ERROR!", 0);
    end

    run_msg("midreq", 1'b0, 1'b1, 24'h081529, time_txt(24'h081529), 1);
    run_msg("endreq", 1'b0, 1'b1, 24'h114433, time_txt(24'h114433), 2);

    // Reset while the fourth byte is on the line
    set_digits(24'h123456);
    @(negedge clk);
    report_req = 1'b1;
    @(negedge clk);
    report_req = 1'b0;
    repeat (3 * 10 * CPB + 10) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_tx", tx, 1);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_idle", busy, 0);
    run_msg("after_rst", 1'b0, 1'b1, 24'h210743, time_txt(24'h210743), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
